// File: rtl/alarm_rtc_pkg.sv
// alarm_rtc_pkg: register map, FSM states and BCD increment helper for the RTC alarm
package alarm_rtc_pkg;
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_TIME_HM  = 3'd2;
    localparam logic [2:0] ADDR_TIME_S   = 3'd3;
    localparam logic [2:0] ADDR_ALARM_HM = 3'd4;
    localparam logic [2:0] ADDR_SNOOZE   = 3'd5;
    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_ALARM_EN = 1;
    localparam int CTRL_RUN      = 2;
    localparam int CTRL_SNOOZE   = 3;
    localparam int CTRL_DISMISS  = 4;
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
    // Returns {carry, next}; invalid or out-of-range fields wrap to 00 with carry.
    function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
        logic wrap;
        wrap = (value[3:0] > 4'd9) || (value[7:4] > 4'd9) || (value >= max);
        return wrap ? 9'h100 : (value[3:0] == 4'd9) ? {1'b0, value[7:4] + 4'd1, 4'd0} : {1'b0, value + 8'd1};
    endfunction
endpackage

// File: rtl/alarm_rtc_bcd_counter.sv
// alarm_rtc_bcd_counter: one 8-bit BCD time field with load, increment and carry out
module alarm_rtc_bcd_counter
    import alarm_rtc_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc_en,
    output logic [7:0] value,
    output logic [7:0] next_value,
    output logic       carry_out
);
    logic [7:0] value_q, value_d;
    logic [8:0] inc;
    always_comb begin
        inc = bcd_inc(value_q, MAX);
        value_d = load ? load_val : inc_en ? inc[7:0] : value_q;
        carry_out = inc_en && inc[8];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) value_q <= '0;
        else value_q <= value_d;
    end
    assign value = value_q;
    assign next_value = value_d;
endmodule

// File: rtl/alarm_qsys_rtc_alarm.sv
// alarm_qsys_rtc_alarm: BCD time-of-day, alarm compare and ring/snooze FSM on a 16-bit Avalon-MM slave.
// Optional ALARM_RTC_TICK_GEN_EN derives the 1 Hz tick internally from CLK_HZ.
module alarm_qsys_rtc_alarm
    import alarm_rtc_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int CLK_HZ         = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        buzzer
);
    logic wr, hm_wr, s_wr, time_wr, tick_i, adv, match, snooze_req, dismiss_req;
    logic sec_carry, min_carry, unused_hr_carry;
    logic [7:0] sec, min, hr, sec_n, min_n, hr_n;
    state_t state_q, state_d;
    logic [7:0] ring_q, ring_d;
    logic [11:0] snz_q, snz_d;
    logic occ_q, occ_d, tset_q, tset_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic [15:0] alarm_q, alarm_d, rd_q, rd_d;

    assign wr = chipselect && !write_n;
    assign hm_wr = wr && address == ADDR_TIME_HM;
    assign s_wr = wr && address == ADDR_TIME_S;
    assign time_wr = hm_wr || s_wr;
    // A time write in the same cycle as a tick swallows that tick for all three fields.
    assign adv = tick_i && ctrl_q[CTRL_RUN] && !time_wr;
    assign snooze_req = wr && address == ADDR_CONTROL && writedata[CTRL_SNOOZE];
    assign dismiss_req = wr && address == ADDR_CONTROL && writedata[CTRL_DISMISS];
    assign match = ctrl_q[CTRL_ALARM_EN] && adv && {hr_n, min_n, sec_n} == {alarm_q, 8'h00};

`ifdef ALARM_RTC_TICK_GEN_EN
    logic [31:0] div_q, div_d;
    logic unused_tick;
    assign unused_tick = tick;
    assign tick_i = div_q == '0;
    assign div_d = (s_wr || tick_i) ? 32'(CLK_HZ - 1) : div_q - 32'd1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_q <= 32'(CLK_HZ - 1);
        else div_q <= div_d;
    end
`else
    logic unused_clk_hz;
    assign unused_clk_hz = ^CLK_HZ;
    assign tick_i = tick;
`endif

    alarm_rtc_bcd_counter #(.MAX(8'h59)) u_sec (
        .clk(clk), .reset_n(reset_n), .load(time_wr), .load_val(hm_wr ? 8'h00 : writedata[7:0]),
        .inc_en(adv), .value(sec), .next_value(sec_n), .carry_out(sec_carry)
    );
    alarm_rtc_bcd_counter #(.MAX(8'h59)) u_min (
        .clk(clk), .reset_n(reset_n), .load(hm_wr), .load_val(writedata[7:0]),
        .inc_en(sec_carry), .value(min), .next_value(min_n), .carry_out(min_carry)
    );
    alarm_rtc_bcd_counter #(.MAX(8'h23)) u_hr (
        .clk(clk), .reset_n(reset_n), .load(hm_wr), .load_val(writedata[15:8]),
        .inc_en(min_carry), .value(hr), .next_value(hr_n), .carry_out(unused_hr_carry)
    );

    always_comb begin
        ctrl_d = (wr && address == ADDR_CONTROL) ? writedata[2:0] : ctrl_q;
        alarm_d = (wr && address == ADDR_ALARM_HM) ? writedata : alarm_q;
        tset_d = tset_q || hm_wr;
        occ_d = occ_q && !(wr && address == ADDR_STATUS);
        state_d = state_q;
        ring_d = ring_q;
        snz_d = snz_q;
        case (state_q)
            IDLE: begin
                if (match) begin
                    state_d = RINGING;
                    ring_d = 8'(RING_SECONDS);
                    occ_d = 1'b1;
                end
            end
            RINGING: begin
                if (dismiss_req) state_d = IDLE;
                else if (snooze_req) begin
                    state_d = SNOOZE;
                    snz_d = 12'(SNOOZE_MINUTES * 60);
                end else if (tick_i) begin
                    ring_d = ring_q - 8'd1;
                    if (ring_q == 8'd1) state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (dismiss_req) begin
                    state_d = IDLE;
                    snz_d = '0;
                end else if (tick_i) begin
                    snz_d = snz_q - 12'd1;
                    if (snz_q == 12'd1) begin
                        state_d = RINGING;
                        ring_d = 8'(RING_SECONDS);
                        occ_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ctrl_d[CTRL_ALARM_EN]) begin
            state_d = IDLE;
            snz_d = '0;
        end
        case (address)
            ADDR_STATUS:   rd_d = {13'b0, tset_q, state_q == RINGING, occ_q};
            ADDR_CONTROL:  rd_d = {13'b0, ctrl_q};
            ADDR_TIME_HM:  rd_d = {hr, min};
            ADDR_TIME_S:   rd_d = {8'b0, sec};
            ADDR_ALARM_HM: rd_d = alarm_q;
            ADDR_SNOOZE:   rd_d = {4'b0, snz_q};
            default:       rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ring_q <= '0;
            snz_q <= '0;
            occ_q <= 1'b0;
            tset_q <= 1'b0;
            ctrl_q <= '0;
            alarm_q <= '0;
            rd_q <= '0;
        end else begin
            state_q <= state_d;
            ring_q <= ring_d;
            snz_q <= snz_d;
            occ_q <= occ_d;
            tset_q <= tset_d;
            ctrl_q <= ctrl_d;
            alarm_q <= alarm_d;
            rd_q <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign buzzer = state_q == RINGING;
    assign irq = occ_q && ctrl_q[CTRL_IRQ_EN];
endmodule

// File: tb/tb_alarm_qsys_rtc_alarm.sv
// tb_alarm_qsys_rtc_alarm: table-driven time vectors plus alarm/snooze/reset sequences
module tb_alarm_qsys_rtc_alarm;
    logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, chipselect = 1'b0, write_n = 1'b1;
    logic [2:0] address = '0;
    logic [15:0] writedata = '0, readdata;
    logic irq, buzzer;
    int passed = 0, total = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] hm;
        logic [7:0]  s;
        int          ticks;
        logic [15:0] exp_hm;
        logic [7:0]  exp_s;
    } vec_t;
    vec_t vecs[7];

    alarm_qsys_rtc_alarm #(.RING_SECONDS(3), .SNOOZE_MINUTES(1)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input logic t);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; tick = t;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] e;
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        chipselect = 1'b0;
        e = exp_q.pop_front();
        check(name, readdata, e);
    endtask

    initial begin
        vecs[0] = '{16'h2359, 8'h58, 2, 16'h0000, 8'h00};
        vecs[1] = '{16'h0959, 8'h59, 1, 16'h1000, 8'h00};
        vecs[2] = '{16'h0009, 8'h09, 1, 16'h0009, 8'h10};
        vecs[3] = '{16'h1259, 8'h59, 1, 16'h1300, 8'h00};
        vecs[4] = '{16'h0000, 8'h00, 3, 16'h0000, 8'h03};
        vecs[5] = '{16'h0945, 8'h5A, 1, 16'h0946, 8'h00};
        vecs[6] = '{16'h2559, 8'h59, 1, 16'h0000, 8'h00};

        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 16'h0);
        check("reset_irq", {15'b0, irq}, 16'h0);
        check("reset_buzzer", {15'b0, buzzer}, 16'h0);
        reset_n = 1'b1;
        read_check("reset_status", 3'd0, 16'h0);
        read_check("reset_time_hm", 3'd2, 16'h0);
        read_check("reset_time_s", 3'd3, 16'h0);

        bus_write(3'd1, 16'h0004, 1'b0);
        foreach (vecs[i]) begin
            bus_write(3'd2, vecs[i].hm, 1'b0);
            bus_write(3'd3, {8'h00, vecs[i].s}, 1'b0);
            do_ticks(vecs[i].ticks);
            read_check($sformatf("vec%0d_hm", i), 3'd2, vecs[i].exp_hm);
            read_check($sformatf("vec%0d_s", i), 3'd3, {8'h00, vecs[i].exp_s});
        end
        read_check("status_time_set", 3'd0, 16'h0004);
        read_check("unmapped_read", 3'd6, 16'h0);

        bus_write(3'd4, 16'h0730, 1'b0);
        bus_write(3'd2, 16'h0729, 1'b0);
        bus_write(3'd3, 16'h0059, 1'b0);
        bus_write(3'd1, 16'h0007, 1'b0);
        check("pre_alarm_buzzer", {15'b0, buzzer}, 16'h0);
        do_ticks(1);
        check("alarm_buzzer", {15'b0, buzzer}, 16'h1);
        check("alarm_irq", {15'b0, irq}, 16'h1);
        read_check("alarm_status", 3'd0, 16'h0007);
        read_check("alarm_time_hm", 3'd2, 16'h0730);

        bus_write(3'd1, 16'h000F, 1'b0);
        check("snooze_buzzer", {15'b0, buzzer}, 16'h0);
        read_check("snooze_left", 3'd5, 16'd60);
        bus_write(3'd0, 16'h0000, 1'b0);
        check("snooze_irq_cleared", {15'b0, irq}, 16'h0);
        do_ticks(59);
        read_check("snooze_left_1", 3'd5, 16'd1);
        check("snooze_still_quiet", {15'b0, buzzer}, 16'h0);
        do_ticks(1);
        check("resnooze_buzzer", {15'b0, buzzer}, 16'h1);
        read_check("resnooze_status", 3'd0, 16'h0007);

        do_ticks(2);
        check("ring_2ticks_buzzer", {15'b0, buzzer}, 16'h1);
        do_ticks(1);
        check("autostop_buzzer", {15'b0, buzzer}, 16'h0);
        check("autostop_irq_held", {15'b0, irq}, 16'h1);
        bus_write(3'd0, 16'h0000, 1'b0);
        check("status_wr_irq", {15'b0, irq}, 16'h0);

        bus_write(3'd2, 16'h1200, 1'b1);
        read_check("collide_hm", 3'd2, 16'h1200);
        read_check("collide_s", 3'd3, 16'h0000);
        bus_write(3'd4, 16'h1201, 1'b0);
        bus_write(3'd3, 16'h0059, 1'b0);
        bus_write(3'd0, 16'h0000, 1'b1);
        check("collide_match_buzzer", {15'b0, buzzer}, 16'h1);
        read_check("collide_status", 3'd0, 16'h0007);

        bus_write(3'd1, 16'h0017, 1'b0);
        check("dismiss_buzzer", {15'b0, buzzer}, 16'h0);
        bus_write(3'd0, 16'h0000, 1'b0);
        bus_write(3'd2, 16'h1201, 1'b0);
        check("time_write_no_trigger", {15'b0, buzzer}, 16'h0);
        read_check("no_trigger_status", 3'd0, 16'h0004);

        bus_write(3'd2, 16'h1200, 1'b0);
        bus_write(3'd3, 16'h0059, 1'b0);
        do_ticks(1);
        check("ring_again", {15'b0, buzzer}, 16'h1);
        bus_write(3'd1, 16'h0005, 1'b0);
        check("alarm_en_clear_idle", {15'b0, buzzer}, 16'h0);
        bus_write(3'd1, 16'h0007, 1'b0);
        bus_write(3'd2, 16'h1200, 1'b0);
        bus_write(3'd3, 16'h0059, 1'b0);
        do_ticks(1);
        check("ring_before_reset", {15'b0, buzzer}, 16'h1);

        address = 3'd2;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_buzzer", {15'b0, buzzer}, 16'h0);
        check("async_reset_irq", {15'b0, irq}, 16'h0);
        check("async_reset_readdata", readdata, 16'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        read_check("post_reset_hm", 3'd2, 16'h0);
        read_check("post_reset_s", 3'd3, 16'h0);
        read_check("post_reset_status", 3'd0, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
